// File: rtl/adder_arb_pkg.sv
// Shared defaults, pointer reset helper and operand-slice macro for the shared adder arbiter.
// Optional signed-overflow flag is enabled by defining ADDER_ARB_OVF_EN.
`ifndef ADDER_ARB_PKG_SV
`define ADDER_ARB_PKG_SV

// Extracts lane idx of width w from a packed per-requester bus.
`define ADDER_ARB_SLICE(bus, idx, w) bus[int'(idx)*(w) +: (w)]

package adder_arb_pkg;
    localparam int ARB_NREQ  = 4;
    localparam int ARB_WIDTH = 32;
    localparam int ARB_IDW   = 2;

    // Pointer reset value: the last requester, so requester 0 wins first.
    function automatic int ptr_rst_val(input int nreq);
        return nreq - 1;
    endfunction
endpackage

`endif

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: searches upward from last+1 with wrap.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = ARB_NREQ,
    parameter int IDW  = ARB_IDW
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    // Priority search starting just after the previously granted requester.
    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        if (en) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = IDW'((int'(last) + k) % NREQ);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    gnt_id   = idx;
                    found    = 1'b1;
                end else begin
                    found = found;
                end
            end
        end else begin
            found = 1'b0;
        end
    end

endmodule

// File: rtl/shared_adder_arbiter.sv
// One registered adder shared by NREQ requesters under round-robin valid/ready arbitration.
// Define ADDER_ARB_OVF_EN to add req_ovf_chk / rsp_ovf signed-overflow reporting.
module shared_adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ  = ARB_NREQ,
    parameter int WIDTH = ARB_WIDTH,
    parameter int IDW   = ARB_IDW
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
`ifdef ADDER_ARB_OVF_EN
    input  logic [NREQ-1:0]       req_ovf_chk,
    output logic                  rsp_ovf,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data
);

    localparam logic [IDW-1:0] LAST_RST = IDW'(ptr_rst_val(NREQ));

    if (IDW != $clog2(NREQ)) begin : g_idw_check
        $error("shared_adder_arbiter: IDW must equal clog2(NREQ)");
    end

    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic [IDW-1:0]   r_last;

    logic             w_slot_free;
    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;

    // A draining slot counts as free; reset_n gating keeps req_ready low while in reset.
    assign w_slot_free = (!r_rsp_valid || rsp_ready) && reset_n;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req    (req_valid),
        .last   (r_last),
        .en     (w_slot_free),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    assign w_accept = |w_gnt;
    assign w_a      = `ADDER_ARB_SLICE(req_a, w_gnt_id, WIDTH);
    assign w_b      = `ADDER_ARB_SLICE(req_b, w_gnt_id, WIDTH);
    assign w_sum    = w_a + w_b;

    // Result slot and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_last      <= LAST_RST;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_gnt_id;
            r_rsp_data  <= w_sum;
            r_last      <= w_gnt_id;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= r_rsp_valid;
        end
    end

`ifdef ADDER_ARB_OVF_EN
    logic r_rsp_ovf;
    logic w_ovf;

    assign w_ovf = req_ovf_chk[w_gnt_id] && (w_a[WIDTH-1] == w_b[WIDTH-1])
                   && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

    // Overflow flag travels with the sum and holds with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_ovf <= 1'b0;
        end else if (w_accept) begin
            r_rsp_ovf <= w_ovf;
        end else begin
            r_rsp_ovf <= r_rsp_ovf;
        end
    end

    assign rsp_ovf = r_rsp_ovf;
`endif

    assign req_ready = w_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed self-checking bench for shared_adder_arbiter (NREQ=4, WIDTH=32).
module tb_shared_adder_arbiter;
    logic         clk;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
`ifdef ADDER_ARB_OVF_EN
    logic [3:0]   req_ovf_chk;
    logic         rsp_ovf;
`endif

    int checks = 0;
    int errors = 0;

    shared_adder_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
`ifdef ADDER_ARB_OVF_EN
        .req_ovf_chk(req_ovf_chk),
        .rsp_ovf    (rsp_ovf),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
`ifdef ADDER_ARB_OVF_EN
        req_ovf_chk = 4'b0000;
`endif
        step();
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp %b", req_ready, 4'b0000); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", rsp_id); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", rsp_data); end
        req_valid = 4'b0000;
        reset_n   = 1'b1;
        step();
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        req_a[31:0] = 32'h0000_0010;
        req_b[31:0] = 32'h0000_0004;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d exp 0", rsp_id); end
        checks++; if (rsp_data !== 32'h0000_0014) begin errors++; $display("FAIL single_data got %h exp 00000014", rsp_data); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0000_0014) begin errors++; $display("FAIL drain_data_hold got %h exp 00000014", rsp_data); end
    endtask

    task automatic test_wrap();
        req_valid = 4'b0100;
        req_a[95:64] = 32'hFFFF_FFFF;
        req_b[95:64] = 32'h0000_0002;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ready got %b exp 0100", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL wrap_id got %0d exp 2", rsp_id); end
        checks++; if (rsp_data !== 32'h0000_0001) begin errors++; $display("FAIL wrap_data got %h exp 00000001", rsp_data); end
        step();
    endtask

    task automatic test_round_robin();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'h100 * i;
            req_b[i*32 +: 32] = 32'h1 * i;
        end
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (req_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, 4'b0001 << (k % 4)); end
            step();
            checks++; if (rsp_id !== 2'(k % 4)) begin errors++; $display("FAIL rr_id[%0d] got %0d exp %0d", k, rsp_id, k % 4); end
            checks++; if (rsp_data !== 32'h101 * (k % 4)) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", k, rsp_data, 32'h101 * (k % 4)); end
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready0 got %b exp 0000", req_ready); end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0000", c, req_ready); end
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'h101) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b id=%0d d=%h exp v=1 id=1 d=00000101", c, rsp_valid, rsp_id, rsp_data); end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b exp 0100", req_ready); end
        step();
        checks++; if (rsp_id !== 2'd2 || rsp_data !== 32'h202) begin errors++; $display("FAIL bp_release_rsp got id=%0d d=%h exp id=2 d=00000202", rsp_id, rsp_data); end
    endtask

    task automatic test_async_reset();
        rsp_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL areset_ready got %b exp 0000", req_ready); end
        #1;
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL areset_first_ready got %b exp 0001", req_ready); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h0) begin
            errors++; $display("FAIL areset_first_rsp got v=%b id=%0d d=%h exp v=1 id=0 d=00000000", rsp_valid, rsp_id, rsp_data); end
        req_valid = 4'b0000;
        step();
    endtask

`ifdef ADDER_ARB_OVF_EN
    task automatic test_ovf();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic        vc [3];
        logic        ve [3];
        va[0] = 32'h7FFF_FFFF; vb[0] = 32'h1;         vc[0] = 1'b1; ve[0] = 1'b1;
        va[1] = 32'h7FFF_FFFF; vb[1] = 32'h1;         vc[1] = 1'b0; ve[1] = 1'b0;
        va[2] = 32'h8000_0000; vb[2] = 32'hFFFF_FFFF; vc[2] = 1'b1; ve[2] = 1'b1;
        rsp_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            req_a[31:0]    = va[t];
            req_b[31:0]    = vb[t];
            req_ovf_chk[0] = vc[t];
            req_valid      = 4'b0001;
            step();
            req_valid = 4'b0000;
            checks++; if (rsp_ovf !== ve[t]) begin errors++; $display("FAIL ovf[%0d] got %b exp %b", t, rsp_ovf, ve[t]); end
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_async_reset();
`ifdef ADDER_ARB_OVF_EN
        test_ovf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
